sorted_vec_serializer: RTL and testbench

//  Consumer end of the bitonic sorter output. Accepts one parallel sorted vector
//  (o_sorted-style, NUM_ELEM x SIZE_DATA) per valid/ready handshake.

---
 rtl/sort_pkg.sv | 17 +
 rtl/sort_order_check.sv | 25 ++
 rtl/sorted_vec_serializer.sv | 105 ++++++++++
 tb/tb_sorted_vec_serializer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/sort_pkg.sv
// Shared types and helpers for the sorted-vector serializer slice.
//   ser_state_t : serializer FSM states (IDLE / SEND)
//   idx_w()     : width of an element index for an n-element vector
//   elem_t      : default 8-bit unsigned element
package sort_pkg;

  typedef enum logic {ST_IDLE, ST_SEND} ser_state_t;

  localparam int unsigned DEF_SIZE_DATA = 8;

  typedef logic [DEF_SIZE_DATA-1:0] elem_t;

  function automatic int unsigned idx_w(input int unsigned n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/sort_order_check.sv
// Combinational ordering checker for a parallel vector.
//   i_vec : NUM_ELEM unsigned elements, index 0 first
//   o_err : 1 when any adjacent pair breaks the IS_ASC ordering
//           (equal neighbours are legal)
module sort_order_check #(
  parameter bit          IS_ASC    = 1'b1,
  parameter int unsigned NUM_ELEM  = 8,
  parameter int unsigned SIZE_DATA = 8
) (
  input  logic [SIZE_DATA-1:0] i_vec [0:NUM_ELEM-1],
  output logic                 o_err
);

  always_comb begin
    o_err = 1'b0;
    for (int unsigned k = 0; k < NUM_ELEM - 1; k++) begin
      if (IS_ASC) begin
        if (i_vec[k] > i_vec[k+1]) o_err = 1'b1;
      end else begin
        if (i_vec[k] < i_vec[k+1]) o_err = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sorted_vec_serializer.sv
// Captures one sorted NUM_ELEM x SIZE_DATA vector per handshake and streams
// it out one element per beat, index 0 first, flagging order violations.
//   i_clk / i_rst_n          : clock, synchronous active-low reset
//   i_vec_valid / o_vec_ready: vector input handshake, i_vec is the vector
//   o_elem_valid / i_elem_ready: element stream handshake
//   o_elem_data / o_elem_idx : current element and its index
//   o_elem_first / o_elem_last: beat is index 0 / index NUM_ELEM-1
//   o_order_err              : last captured vector broke IS_ASC order
//   o_busy                   : FSM not idle
module sorted_vec_serializer
  import sort_pkg::*;
#(
  parameter bit          IS_ASC    = 1'b1,
  parameter int unsigned NUM_ELEM  = 8,
  parameter int unsigned SIZE_DATA = 8
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_vec_valid,
  output logic                          o_vec_ready,
  input  logic [SIZE_DATA-1:0]          i_vec [0:NUM_ELEM-1],
  output logic                          o_elem_valid,
  input  logic                          i_elem_ready,
  output logic [SIZE_DATA-1:0]          o_elem_data,
  output logic [idx_w(NUM_ELEM)-1:0]    o_elem_idx,
  output logic                          o_elem_first,
  output logic                          o_elem_last,
  output logic                          o_order_err,
  output logic                          o_busy
);

  localparam int unsigned IDX_W = idx_w(NUM_ELEM);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_ELEM - 1);

  ser_state_t           state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [SIZE_DATA-1:0] buf_q [0:NUM_ELEM-1];
  logic [SIZE_DATA-1:0] buf_d [0:NUM_ELEM-1];
  logic                 err_q, err_d;

  logic vec_err;
  logic capture;
  logic beat_done;

  sort_order_check #(
    .IS_ASC   (IS_ASC),
    .NUM_ELEM (NUM_ELEM),
    .SIZE_DATA(SIZE_DATA)
  ) u_order_check (
    .i_vec(i_vec),
    .o_err(vec_err)
  );

  always_comb begin
    o_elem_valid = (state_q == ST_SEND);
    o_elem_first = o_elem_valid && (idx_q == '0);
    o_elem_last  = o_elem_valid && (idx_q == IDX_LAST);
    o_elem_data  = buf_q[idx_q];
    o_elem_idx   = idx_q;
    o_order_err  = err_q;
    o_busy       = (state_q != ST_IDLE);
    // Accept a new vector on the same edge the last beat leaves, so a
    // full-rate producer sees no bubble between vectors.
    o_vec_ready  = (state_q == ST_IDLE) || (o_elem_last && i_elem_ready);
    capture      = i_vec_valid && o_vec_ready;
    beat_done    = o_elem_valid && i_elem_ready;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    buf_d   = buf_q;
    err_d   = err_q;
    if (beat_done) begin
      if (idx_q == IDX_LAST) begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
    // Capture overrides the last-beat return to IDLE.
    if (capture) begin
      state_d = ST_SEND;
      idx_d   = '0;
      buf_d   = i_vec;
      err_d   = vec_err;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      buf_q   <= '{default: '0};
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_sorted_vec_serializer.sv
// Directed self-checking bench for sorted_vec_serializer (ascending DUT plus
// a descending instance for the IS_ASC=0 order check).
module tb_sorted_vec_serializer;

  typedef logic [7:0] vec_t [0:7];

  logic       clk = 1'b0;
  logic       rst_n;
  logic       vec_valid;
  logic       vec_ready;
  vec_t       vec;
  logic       elem_valid;
  logic       elem_ready;
  logic [7:0] elem_data;
  logic [2:0] elem_idx;
  logic       elem_first;
  logic       elem_last;
  logic       order_err;
  logic       busy;

  logic       d_vec_valid;
  logic       d_vec_ready;
  vec_t       d_vec;
  logic       d_elem_valid;
  logic [7:0] d_elem_data;
  logic [2:0] d_elem_idx;
  logic       d_elem_first;
  logic       d_elem_last;
  logic       d_order_err;
  logic       d_busy;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sorted_vec_serializer #(
    .IS_ASC   (1'b1),
    .NUM_ELEM (8),
    .SIZE_DATA(8)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_vec_valid (vec_valid),
    .o_vec_ready (vec_ready),
    .i_vec       (vec),
    .o_elem_valid(elem_valid),
    .i_elem_ready(elem_ready),
    .o_elem_data (elem_data),
    .o_elem_idx  (elem_idx),
    .o_elem_first(elem_first),
    .o_elem_last (elem_last),
    .o_order_err (order_err),
    .o_busy      (busy)
  );

  sorted_vec_serializer #(
    .IS_ASC   (1'b0),
    .NUM_ELEM (8),
    .SIZE_DATA(8)
  ) dut_desc (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_vec_valid (d_vec_valid),
    .o_vec_ready (d_vec_ready),
    .i_vec       (d_vec),
    .o_elem_valid(d_elem_valid),
    .i_elem_ready(1'b1),
    .o_elem_data (d_elem_data),
    .o_elem_idx  (d_elem_idx),
    .o_elem_first(d_elem_first),
    .o_elem_last (d_elem_last),
    .o_order_err (d_order_err),
    .o_busy      (d_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a vector and let the DUT capture it on the next edge.
  task automatic capture_vec(input vec_t v);
    vec       = v;
    vec_valid = 1'b1;
    #1;
    check("cap_ready", {31'd0, vec_ready}, 32'd1);
    tick();
    vec_valid = 1'b0;
  endtask

  // Walk the 8 beats of a captured vector. Optional 3-cycle stalls on beats
  // 2 and 5 (with a junk vector offered meanwhile), optional chained vector
  // offered during the last beat. cyc counts cycles from first beat to done.
  task automatic stream(input vec_t v, input bit exp_err, input bit stall,
                        input bit chain, input vec_t nv, output int cyc);
    vec_t junk;
    junk = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF, 8'h11, 8'h22};
    cyc  = 0;
    for (int b = 0; b < 8; b++) begin
      if (stall && (b == 2 || b == 5)) begin
        elem_ready = 1'b0;
        vec        = junk;
        vec_valid  = 1'b1;
        for (int s = 0; s < 3; s++) begin
          #1;
          check("stall_valid", {31'd0, elem_valid}, 32'd1);
          check("stall_data", {24'd0, elem_data}, {24'd0, v[b]});
          check("stall_idx", {29'd0, elem_idx}, b);
          check("stall_vready", {31'd0, vec_ready}, 32'd0);
          tick();
          cyc++;
        end
        vec_valid  = 1'b0;
        elem_ready = 1'b1;
      end
      if (chain && b == 7) begin
        vec       = nv;
        vec_valid = 1'b1;
      end
      #1;
      check("beat_valid", {31'd0, elem_valid}, 32'd1);
      check("beat_data", {24'd0, elem_data}, {24'd0, v[b]});
      check("beat_idx", {29'd0, elem_idx}, b);
      check("beat_first", {31'd0, elem_first}, (b == 0) ? 32'd1 : 32'd0);
      check("beat_last", {31'd0, elem_last}, (b == 7) ? 32'd1 : 32'd0);
      check("beat_err", {31'd0, order_err}, {31'd0, exp_err});
      check("beat_vready", {31'd0, vec_ready}, (b == 7) ? 32'd1 : 32'd0);
      tick();
      cyc++;
      vec_valid = 1'b0;
    end
  endtask

  initial begin
    vec_t va, vb, vu, vd, vz;
    int   cyc;
    va = '{8'd0, 8'd0, 8'd5, 8'd35, 8'd55, 8'd77, 8'd100, 8'd120};
    vb = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    vu = '{8'd35, 8'd120, 8'd0, 8'd0, 8'd55, 8'd100, 8'd77, 8'd5};
    vd = '{8'd120, 8'd100, 8'd77, 8'd55, 8'd35, 8'd5, 8'd0, 8'd0};
    vz = '{default: 8'd0};

    // 1. Reset held 3 cycles with a vector offered.
    rst_n       = 1'b0;
    vec         = va;
    vec_valid   = 1'b1;
    elem_ready  = 1'b1;
    d_vec       = vz;
    d_vec_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_valid", {31'd0, elem_valid}, 32'd0);
      check("rst_vready", {31'd0, vec_ready}, 32'd1);
      check("rst_err", {31'd0, order_err}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
    end
    vec_valid = 1'b0;
    rst_n     = 1'b1;
    tick();
    check("post_rst_valid", {31'd0, elem_valid}, 32'd0);

    // 2 + 4. Sorted vector at full rate, second vector chained on last beat.
    capture_vec(va);
    stream(va, 1'b0, 1'b0, 1'b1, vb, cyc);
    stream(vb, 1'b0, 1'b0, 1'b0, vz, cyc);
    check("b2b_cycles", cyc, 32'd8);
    check("idle_valid", {31'd0, elem_valid}, 32'd0);
    check("idle_vready", {31'd0, vec_ready}, 32'd1);

    // 3. Stalls on beats 2 and 5.
    capture_vec(va);
    stream(va, 1'b0, 1'b1, 1'b0, vz, cyc);
    check("stall_cycles", cyc, 32'd14);

    // 5. Unsorted vector flags error; flag holds until next capture.
    capture_vec(vu);
    stream(vu, 1'b1, 1'b0, 1'b0, vz, cyc);
    #1;
    check("err_hold_idle", {31'd0, order_err}, 32'd1);
    capture_vec(va);
    stream(va, 1'b0, 1'b0, 1'b0, vz, cyc);

    // 5b. Descending instance: descending vector clean, ascending unsorted.
    d_vec       = vd;
    d_vec_valid = 1'b1;
    tick();
    d_vec_valid = 1'b0;
    check("desc_valid", {31'd0, d_elem_valid}, 32'd1);
    check("desc_data0", {24'd0, d_elem_data}, 32'd120);
    check("desc_err_clean", {31'd0, d_order_err}, 32'd0);
    for (int i = 0; i < 8; i++) tick();
    check("desc_idle", {31'd0, d_elem_valid}, 32'd0);
    d_vec       = vb;
    d_vec_valid = 1'b1;
    tick();
    d_vec_valid = 1'b0;
    check("desc_err_bad", {31'd0, d_order_err}, 32'd1);

    // 6. Reset at beat 3 of a vector.
    capture_vec(vb);
    for (int b = 0; b < 3; b++) tick();
    check("mid_idx3", {29'd0, elem_idx}, 32'd3);
    check("mid_data3", {24'd0, elem_data}, 32'd4);
    rst_n = 1'b0;
    tick();
    check("mid_rst_valid", {31'd0, elem_valid}, 32'd0);
    check("mid_rst_vready", {31'd0, vec_ready}, 32'd1);
    rst_n = 1'b1;
    tick();
    check("mid_post_valid", {31'd0, elem_valid}, 32'd0);
    check("mid_post_vready", {31'd0, vec_ready}, 32'd1);
    capture_vec(va);
    stream(va, 1'b0, 1'b0, 1'b0, vz, cyc);
    #1;
    check("final_idle", {31'd0, elem_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
